// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end.
//   WIDTH / M / N : default sample width and FFT size (N = 2**M points)
//   complex_t     : packed {re, im} word as consumed by fft_top
//   loader_state_t: sample loader FSM states
//   bitrev()      : reverses the low 'bits' bits of an index
package fft_pkg;
  localparam int WIDTH = 16;
  localparam int M     = 5;
  localparam int N     = 2 ** M;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } complex_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FILL, S_START, S_WAIT, S_HOLD
  } loader_state_t;

  // Width-agnostic so loaders built with a non-default M can share it;
  // 'bits' is always an elaboration constant at the call site.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < bits) r[bits-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/sample_decimator.sv
// Keep-1-of-DECIM filter for the loader's sample stream.
//   clk, reset   : clock, async active-low reset
//   en           : counting window (loader in FILL and enabled)
//   clr          : restart the count at the next edge
//   sample_valid : incoming sample strobe
//   accept       : this valid sample is kept (combinational)
module sample_decimator #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic sample_valid,
  output logic accept
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] cnt;

  // The first valid sample of every group of DECIM is the one kept.
  assign accept = en && sample_valid && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && sample_valid)
      cnt <= (cnt == CW'(DECIM - 1)) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/fft_sample_loader.sv
// Frames the audio sample stream into N = 2**M real samples, loads them
// into fft_top, kicks the transform and hands results to the reader.
//   clk, reset      : clock, async active-low reset
//   enable          : run frames continuously while high
//   sample_valid/in : signed audio sample stream
//   fft_done        : fft_top done level
//   result_ack      : reader finished with the results (pulse)
//   clr_overrun     : clears the sticky overrun flag
//   fft_clr         : clear pulse to fft_top ahead of each frame
//   load/rd_adr/rd  : fft_top load port, rd = {sample>>>SHIFT, 0}
//   start           : transform kick after the last load
//   frame_done      : results valid pulse
//   busy            : FSM not idle
//   overrun         : sticky, sample arrived outside FILL
module fft_sample_loader #(
  parameter int width  = fft_pkg::WIDTH,
  parameter int M      = fft_pkg::M,
  parameter int SHIFT  = 5,
  parameter int DECIM  = 1,
  parameter int BITREV = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sample_valid,
  input  logic signed [width-1:0]   sample_in,
  input  logic                      fft_done,
  input  logic                      result_ack,
  input  logic                      clr_overrun,
  output logic                      fft_clr,
  output logic                      load,
  output logic [M-1:0]              rd_adr,
  output logic [2*width-1:0]        rd,
  output logic                      start,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      overrun
);
  import fft_pkg::*;

  localparam int FRAME_N = 2 ** M;

  loader_state_t              state, nxt;
  logic [M-1:0]               idx;
  logic                       wait_first;
  logic                       accept;
  logic signed [width-1:0]    scaled;

  assign scaled = sample_in >>> SHIFT;

  sample_decimator #(.DECIM(DECIM)) u_dec (
    .clk          (clk),
    .reset        (reset),
    .en           (state == S_FILL && enable),
    .clr          (state == S_CLEAR),
    .sample_valid (sample_valid),
    .accept       (accept)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (enable) nxt = S_CLEAR;
      S_CLEAR: nxt = S_FILL;
      // Dropping enable abandons the partial frame; the last accept
      // moves on so its load cycle already runs in START.
      S_FILL:  if (!enable) nxt = S_IDLE;
               else if (accept && idx == M'(FRAME_N - 1)) nxt = S_START;
      S_START: nxt = S_WAIT;
      // fft_done may still be high from the previous frame in the
      // cycle right after start, so that cycle is not trusted.
      S_WAIT:  if (!wait_first && fft_done) nxt = S_HOLD;
      S_HOLD:  if (result_ack) nxt = enable ? S_CLEAR : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state / current transition so every
  // one of them is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      wait_first <= 1'b0;
      fft_clr    <= 1'b0;
      load       <= 1'b0;
      rd_adr     <= '0;
      rd         <= '0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= nxt;
      busy       <= (nxt != S_IDLE);
      fft_clr    <= (nxt == S_CLEAR);
      load       <= accept;
      start      <= (state == S_START);
      wait_first <= (state == S_START);
      frame_done <= (state == S_WAIT) && (nxt == S_HOLD);

      if (state == S_CLEAR) idx <= '0;
      else if (accept)      idx <= idx + 1'b1;

      if (accept) begin
        rd_adr <= (BITREV != 0) ? M'(bitrev(32'(idx), M)) : idx;
        rd     <= {scaled, {width{1'b0}}};
      end

      // Set has priority over clear.
      if (sample_valid && state != S_FILL) overrun <= 1'b1;
      else if (clr_overrun)                overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_sample_loader.sv
module tb_fft_sample_loader;
  localparam int NP = 32;

  typedef struct { logic [4:0] adr; logic [31:0] rd; } ld_t;
  typedef struct { logic [15:0] s; logic [31:0] exp_rd; } vec_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  en = '0;
  logic        sample_valid = 1'b0, fft_done = 1'b0, result_ack = 1'b0, clr_overrun = 1'b0;
  logic [15:0] sample_in = '0;
  logic [1:0]  fft_clr, load, start, frame_done, busy, overrun;
  logic [4:0]  rd_adr [2];
  logic [31:0] rd [2];

  int passed = 0, total = 0, cyc = 0;
  ld_t q0[$], q1[$];
  int  nload[2], nstart[2], nfd[2], last_ld[2], start_cyc[2], fd_cyc[2];
  bit  start_seen[2], fd_seen[2];
  logic [15:0] stim[128];
  logic [31:0] exp_rd[128];
  vec_t vec[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: natural order, keep all.  B: bit-reversed, keep 1 of 4.
  fft_sample_loader #(.width(16), .M(5), .SHIFT(5), .DECIM(1), .BITREV(0)) dut_a (
    .clk(clk), .reset(reset), .enable(en[0]), .sample_valid(sample_valid),
    .sample_in(sample_in), .fft_done(fft_done), .result_ack(result_ack),
    .clr_overrun(clr_overrun), .fft_clr(fft_clr[0]), .load(load[0]),
    .rd_adr(rd_adr[0]), .rd(rd[0]), .start(start[0]), .frame_done(frame_done[0]),
    .busy(busy[0]), .overrun(overrun[0]));

  fft_sample_loader #(.width(16), .M(5), .SHIFT(5), .DECIM(4), .BITREV(1)) dut_b (
    .clk(clk), .reset(reset), .enable(en[1]), .sample_valid(sample_valid),
    .sample_in(sample_in), .fft_done(fft_done), .result_ack(result_ack),
    .clr_overrun(clr_overrun), .fft_clr(fft_clr[1]), .load(load[1]),
    .rd_adr(rd_adr[1]), .rd(rd[1]), .start(start[1]), .frame_done(frame_done[1]),
    .busy(busy[1]), .overrun(overrun[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: real part = floor(sample / 2**SHIFT), imag = 0.
  function automatic logic [31:0] fmt(input logic [15:0] s);
    int v, q;
    v = $signed(s);
    q = (v - (((v % 32) + 32) % 32)) / 32;
    return {q[15:0], 16'h0000};
  endfunction

  function automatic logic [4:0] brev(input int k);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) r[4-b] = k[b];
    return r;
  endfunction

  // Load / start / frame_done monitor.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (load[s]) begin
        ld_t e;
        if ((s == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check("unexpected_load", 1, 0);
        end else begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          check(s == 0 ? "load_adr_a" : "load_adr_b", rd_adr[s], e.adr);
          check(s == 0 ? "load_rd_a" : "load_rd_b", rd[s], e.rd);
        end
        if (s == 1 && nload[1] == 1) check("bitrev_idx1", rd_adr[1], 5'b10000);
        if (s == 1 && nload[1] == 6) check("bitrev_idx6", rd_adr[1], 5'b01100);
        nload[s]++;
        last_ld[s] = cyc;
      end
      if (start[s])      begin start_seen[s] = 1; start_cyc[s] = cyc; nstart[s]++; end
      if (frame_done[s]) begin fd_seen[s] = 1;    fd_cyc[s] = cyc;    nfd[s]++;    end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic open_frame(input int s);
    int n;
    n = 0;
    while (!fft_clr[s] && n < 20) begin tick(); n++; end
    check("fft_clr_pulse", fft_clr[s], 1);
    tick();
    check("fft_clr_width", fft_clr[s], 0);
    nload[s] = 0; nstart[s] = 0; nfd[s] = 0;
    start_seen[s] = 0; fd_seen[s] = 0;
  endtask

  task automatic feed(input int s, input int nv, input int dec, input bit gaps);
    int acc;
    ld_t e;
    acc = 0;
    for (int i = 0; i < nv; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          sample_valid = 0; sample_in = 16'($urandom); tick();
        end
      sample_valid = 1; sample_in = stim[i];
      if (i % dec == 0 && acc < NP) begin
        e.adr = (s == 1) ? brev(acc) : 5'(acc);
        e.rd  = exp_rd[i];
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        acc++;
      end
      tick();
    end
    sample_valid = 0;
  endtask

  task automatic finish_frame(input int s, input bit keep_en, input bit lat);
    int n;
    n = 0;
    while (!fd_seen[s] && n < 80) begin tick(); n++; end
    check("frame_done_seen", fd_seen[s], 1);
    check("start_after_last_load", start_cyc[s] - last_ld[s], 1);
    if (lat) check("frame_done_latency", fd_cyc[s] - start_cyc[s], 2);
    check("loads_per_frame", nload[s], NP);
    check("queue_drained", (s == 0) ? q0.size() : q1.size(), 0);
    en[s] = keep_en; result_ack = 1; tick(); result_ack = 0;
    check("single_start", nstart[s], 1);
    check("single_frame_done", nfd[s], 1);
    if (!keep_en) begin
      tick();
      check("idle_after_ack", busy[s], 0);
    end
  endtask

  task automatic rand_stim();
    for (int i = 0; i < 128; i++) begin
      stim[i] = 16'($urandom);
      exp_rd[i] = fmt(stim[i]);
    end
  endtask

  initial begin
    vec[0] = '{16'h8000, 32'hFC00_0000};
    vec[1] = '{16'h7FFF, 32'h03FF_0000};
    vec[2] = '{16'h0000, 32'h0000_0000};
    vec[3] = '{16'hFFFF, 32'hFFFF_0000};
    vec[4] = '{16'h0020, 32'h0001_0000};
    vec[5] = '{16'hFFE0, 32'hFFFF_0000};
    vec[6] = '{16'hFFDF, 32'hFFFE_0000};
    vec[7] = '{16'h001F, 32'h0000_0000};

    fft_done = 1;
    tick(); tick();
    for (int s = 0; s < 2; s++)
      check("reset_outputs", {fft_clr[s], load[s], rd_adr[s], rd[s], start[s],
                              frame_done[s], busy[s], overrun[s]}, '0);
    reset = 1; tick();

    // Samples 0..31 back to back, natural order.
    for (int i = 0; i < NP; i++) begin stim[i] = 16'(i); exp_rd[i] = fmt(stim[i]); end
    en[0] = 1; tick();
    open_frame(0);
    feed(0, NP, 1, 0);
    finish_frame(0, 1, 1);

    // Table-driven formatting vectors at the head of a frame.
    rand_stim();
    for (int i = 0; i < 8; i++) begin stim[i] = vec[i].s; exp_rd[i] = vec[i].exp_rd; end
    open_frame(0);
    feed(0, NP, 1, 0);
    finish_frame(0, 1, 1);

    // Random samples with random gaps.
    for (int f = 0; f < 2; f++) begin
      rand_stim();
      open_frame(0);
      feed(0, NP, 1, 1);
      finish_frame(0, 1, 1);
    end

    // Reset in the middle of a frame at idx 7.
    rand_stim();
    open_frame(0);
    feed(0, 7, 1, 0);
    tick(); tick();
    check("loads_before_reset", nload[0], 7);
    reset = 0; #1;
    check("async_reset_outputs", {fft_clr[0], load[0], rd_adr[0], rd[0], start[0],
                                  frame_done[0], busy[0], overrun[0]}, '0);
    q0.delete();
    tick(); reset = 1; tick();
    rand_stim();
    open_frame(0);
    feed(0, NP, 1, 1);
    finish_frame(0, 0, 1);

    // Decimate by 4, bit-reversed: sample i carries value i so rd.re = i.
    for (int i = 0; i < 128; i++) begin stim[i] = 16'(i << 5); exp_rd[i] = fmt(stim[i]); end
    en[1] = 1; tick();
    open_frame(1);
    feed(1, 128, 4, 0);
    finish_frame(1, 1, 1);
    rand_stim();
    open_frame(1);
    feed(1, 128, 4, 1);
    finish_frame(1, 0, 1);

    // Samples during WAIT, late fft_done, ack with enable held.
    fft_done = 0;
    clr_overrun = 1; tick(); clr_overrun = 0;
    check("overrun_cleared", overrun[0], 0);
    en[0] = 1; tick();
    rand_stim();
    open_frame(0);
    feed(0, NP, 1, 1);
    for (int n = 0; n < 20 && !start_seen[0]; n++) tick();
    check("start_seen", start_seen[0], 1);
    sample_valid = 1; tick(); tick(); tick(); sample_valid = 0; tick();
    check("no_load_in_wait", nload[0], NP);
    check("overrun_set", overrun[0], 1);
    check("no_frame_done_without_fft_done", fd_seen[0], 0);
    sample_valid = 1; clr_overrun = 1; tick(); sample_valid = 0; clr_overrun = 0;
    check("overrun_set_wins", overrun[0], 1);
    fft_done = 1;
    finish_frame(0, 1, 0);
    open_frame(0);
    check("busy_in_fill", busy[0], 1);
    clr_overrun = 1; tick(); clr_overrun = 0;
    check("clr_overrun", overrun[0], 0);

    // Enable dropped mid-FILL: partial frame discarded, no start.
    rand_stim();
    feed(0, 5, 1, 0);
    en[0] = 0; tick(); tick();
    check("abort_idle", busy[0], 0);
    tick(); tick();
    check("abort_no_start", start_seen[0], 0);
    check("abort_loads", nload[0], 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
